ps2_tx: RTL and testbench
=========================

PS2_TX -- requirements
Module: ps2_tx

Interface
REQ-001 Parameter HOLD_CYCLES, default 10000, sets the request-to-send clock-low hold time in clk cycles (100 us at 100 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 2000000, is the maximum clk cycles between device clock falling edges before the transfer aborts.
REQ-003 Parameter FILTER_LEN, default 8, is the number of consecutive equal ps2c samples that change the filtered clock.
REQ-004 Port clk  input  1  system clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port wr_ps2  input  1  one-cycle request to send din.
REQ-007 Port din  input  8  command byte to transmit.
REQ-008 Port ps2c  inout  1  PS/2 clock, open-drain: the block drives only 0, otherwise high-Z.
REQ-009 Port ps2d  inout  1  PS/2 data, open-drain: the block drives only 0, otherwise high-Z.
REQ-010 Port tx_idle  output  1  high only in IDLE; the top level gates the receiver enable with it.
REQ-011 Port tx_done_tick  output  1  one-cycle pulse when a transfer ends, whether it succeeds or fails.
REQ-012 Port tx_err  output  1  one-cycle pulse coincident with tx_done_tick on NACK or timeout.

Function
REQ-013 Filter: shift ps2c into a FILTER_LEN-bit register each cycle; filtered clock goes to 1 on all-ones and to 0 on all-zeros, otherwise it holds.
REQ-014 fall_edge is a one-cycle pulse on the filtered clock's 1->0 transition, one cycle after the filter settles.
REQ-015 Frame: start bit 0, din[7:0] LSB first, odd parity bit (~^din), stop (data released), then the device ack.
REQ-016 States are IDLE, RTS, START, DATA, STOP and ACK; the block drives ps2c only in RTS.
REQ-017 IDLE: both lines released; on wr_ps2, latch {parity, din} into a 9-bit shift register, load the counter with HOLD_CYCLES-1, and go to RTS.
REQ-018 IDLE ignores fall_edge.
REQ-019 wr_ps2 outside IDLE is ignored; din is not re-latched.
REQ-020 RTS: drive ps2c=0 and release ps2d; decrement each cycle; at count 0, go to START.
REQ-021 START: release ps2c, drive ps2d=0, load the timeout counter; on fall_edge, go to DATA with the bit count set to 8.
REQ-022 DATA: drive ps2d=0 when shift[0]=0, else release it.
REQ-023 DATA: on each fall_edge, shift right; when the bit count is 0 go to STOP, else decrement the bit count.
REQ-024 Exactly 9 bits leave DATA: 8 data bits plus parity.
REQ-025 STOP: release ps2d; on fall_edge go to ACK.
REQ-026 ACK: on fall_edge, sample ps2d; 0 means acknowledged, 1 means NACK.
REQ-027 Leaving ACK returns to IDLE, pulses tx_done_tick, and pulses tx_err only on NACK.
REQ-028 Timeout: in START, DATA, STOP and ACK, reload the timeout counter on each fall_edge.
REQ-029 Timeout: if the counter reaches 0 with no fall_edge, release both lines, go to IDLE, and pulse tx_done_tick and tx_err together.
REQ-030 If fall_edge and timeout expiry coincide, fall_edge wins.
REQ-031 Drive-value changes follow fall_edge by one cycle; data is stable well before the device samples on the rising clock.
REQ-032 Counter widths cover max(HOLD_CYCLES, TIMEOUT_CYCLES) without overflow.

Reset
REQ-033 Asynchronous reset, at any point including mid-frame, forces IDLE, releases both lines, and sets tx_idle=1.
REQ-034 Reset forces tx_done_tick=0, tx_err=0, the filter register to all ones, filtered clock=1, and the shift register and counters to 0.
REQ-035 After reset deasserts, the block takes no action until wr_ps2.

Verification (bench: HOLD_CYCLES=20, TIMEOUT_CYCLES=500, FILTER_LEN=8, device model clock period 200 cycles)
REQ-036 wr_ps2 with din=0xED: ps2c is low for 20 cycles, then data low; the bits seen on device rising edges are 1,0,1,1,0,1,1,1, then parity 1, then stop 1; device ack 0 gives tx_done_tick=1 with tx_err=0 and tx_idle=1.
REQ-037 din=0xF4: the parity bit seen by the device is 0; otherwise the frame is as in REQ-036 and completes without error.
REQ-038 The device leaves ps2d high at the ack clock: tx_done_tick and tx_err pulse together for one cycle.
REQ-039 The device stops clocking after bit 3: 500 cycles after the last fall_edge, both lines float and tx_err=1; a following wr_ps2 starts a clean frame.
REQ-040 A 3-cycle glitch low on ps2c in START produces no fall_edge and no state change; a second wr_ps2 with 0x00 mid-frame leaves the transmitted byte unchanged.
REQ-041 Reset asserted in DATA releases both lines in the same cycle, sets tx_idle=1, and produces no tx_done_tick.

Source files
------------

// File: rtl/ps2_tx.sv
// rtl/ps2_tx.sv - PS/2 host-to-device command transmitter with clock filter and timeout
module ps2_tx #(
  parameter int HOLD_CYCLES    = 10000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  inout  wire        ps2c,
  inout  wire        ps2d,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err
);

  localparam int CNT_MAX = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TO_LOAD   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {IDLE, RTS, START, DATA, STOP, ACK} state_t;

  state_t                state_q, state_d;
  logic [FILTER_LEN-1:0] filter_q, filter_d;
  logic                  fclk_q, fclk_d;
  logic [8:0]            shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [3:0]            bits_q, bits_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  fall_edge;
  logic                  c_low, d_low;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      filter_q <= '1;
      fclk_q   <= 1'b1;
      shift_q  <= '0;
      cnt_q    <= '0;
      bits_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      filter_q <= filter_d;
      fclk_q   <= fclk_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      bits_q   <= bits_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Filtered clock only moves once FILTER_LEN consecutive samples agree.
  always_comb begin
    filter_d = {ps2c, filter_q[FILTER_LEN-1:1]};
    fclk_d   = fclk_q;
    if (&filter_q) begin
      fclk_d = 1'b1;
    end else if (~|filter_q) begin
      fclk_d = 1'b0;
    end
    fall_edge = fclk_q & ~fclk_d;
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    bits_d  = bits_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    c_low   = 1'b0;
    d_low   = 1'b0;

    case (state_q)
      IDLE: begin
        if (wr_ps2) begin
          shift_d = {~^din, din};
          cnt_d   = HOLD_LOAD;
          state_d = RTS;
        end
      end
      RTS: begin
        c_low = 1'b1;
        if (cnt_q == '0) begin
          cnt_d   = TO_LOAD;
          state_d = START;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      START:   d_low = 1'b1;
      DATA:    d_low = ~shift_q[0];
      default: ;
    endcase

    // Device-clocked phases share one watchdog; a real edge always beats expiry.
    if (state_q == START || state_q == DATA || state_q == STOP || state_q == ACK) begin
      if (fall_edge) begin
        cnt_d = TO_LOAD;
        case (state_q)
          START: begin
            bits_d  = 4'd8;
            state_d = DATA;
          end
          DATA: begin
            shift_d = {1'b0, shift_q[8:1]};
            if (bits_q == 4'd0) begin
              state_d = STOP;
            end else begin
              bits_d = bits_q - 4'd1;
            end
          end
          STOP: state_d = ACK;
          default: begin
            state_d = IDLE;
            done_d  = 1'b1;
            err_d   = ps2d;
          end
        endcase
      end else if (cnt_q == '0) begin
        state_d = IDLE;
        done_d  = 1'b1;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end
  end

  assign ps2c         = c_low ? 1'b0 : 1'bz;
  assign ps2d         = d_low ? 1'b0 : 1'bz;
  assign tx_idle      = (state_q == IDLE);
  assign tx_done_tick = done_q;
  assign tx_err       = err_q;

endmodule

// File: tb/tb_ps2_tx.sv
// tb/tb_ps2_tx.sv - self-checking bench for ps2_tx with a PS/2 device model
module tb_ps2_tx;
  localparam int HOLD = 20;
  localparam int TMO  = 500;
  localparam int FL   = 8;
  localparam int HALF = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = 8'h00;
  wire        ps2c;
  wire        ps2d;
  logic       tx_idle, tx_done_tick, tx_err;
  logic       dev_c_low = 1'b0;
  logic       dev_d_low = 1'b0;

  pullup (ps2c);
  pullup (ps2d);
  assign ps2c = dev_c_low ? 1'b0 : 1'bz;
  assign ps2d = dev_d_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  ps2_tx #(.HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(FL)) dut (
    .clk(clk), .reset(reset), .wr_ps2(wr_ps2), .din(din),
    .ps2c(ps2c), .ps2d(ps2d),
    .tx_idle(tx_idle), .tx_done_tick(tx_done_tick), .tx_err(tx_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, rts_cnt = 0;
  int done_cyc = 0, last_fall_cyc = 0;
  bit model_idle = 1'b0;
  bit done_allowed = 1'b0;
  logic [9:0] seen;

  always @(posedge clk) cyc <= cyc + 1;

  // Device-visible frame: bits 7:0 data LSB first, bit 8 odd parity, bit 9 stop.
  function automatic logic [9:0] model_frame(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (tx_err) check("err_with_done", tx_done_tick, 1);
      if (tx_done_tick) begin
        done_cnt++;
        if (tx_err) err_cnt++;
        done_cyc = cyc;
        check("done_expected", done_allowed, 1);
      end
      if (ps2c === 1'b0 && !dev_c_low) begin
        rts_cnt++;
        check("busy_while_rts", tx_idle, 0);
      end
      if (model_idle) begin
        check("idle_flag", tx_idle, 1);
        if (!dev_c_low) check("idle_ps2c", ps2c, 1);
        if (!dev_d_low) check("idle_ps2d", ps2d, 1);
      end
    end
  end

  task automatic clear_counts();
    done_cnt = 0; err_cnt = 0; rts_cnt = 0;
  endtask

  task automatic send(input logic [7:0] b);
    model_idle = 1'b0;
    din = b;
    wr_ps2 = 1'b1;
    step(1);
    wr_ps2 = 1'b0;
  endtask

  task automatic dev_frame(input int nclk, input bit ack_low, input bit glitch, output logic [9:0] bits);
    int t = 0;
    bits = '0;
    while (!(ps2c === 1'b1 && ps2d === 1'b0) && t < 2000) begin
      step(1);
      t++;
    end
    check("start_seen", (t < 2000), 1);
    if (t < 2000) begin
      if (glitch) begin
        step(20);
        dev_c_low = 1'b1;
        step(3);
        dev_c_low = 1'b0;
        step(20);
        check("glitch_still_busy", tx_idle, 0);
        check("glitch_start_low", ps2d, 0);
      end
      step(30);
      for (int i = 0; i < nclk; i++) begin
        if (i == 11) done_allowed = 1'b1;
        dev_c_low = 1'b1;
        last_fall_cyc = cyc;
        step(HALF);
        dev_c_low = 1'b0;
        if (i < 10) bits[i] = ps2d;
        if (i == 9 && ack_low) dev_d_low = 1'b1;
        if (i == 11) dev_d_low = 1'b0;
        step(HALF);
      end
    end
  endtask

  task automatic run_frame(input logic [7:0] b, input bit ack_low, input bit glitch, input bit mid_wr);
    clear_counts();
    send(b);
    fork
      dev_frame(12, ack_low, glitch, seen);
      if (mid_wr) begin
        step(700);
        din = 8'h00;
        wr_ps2 = 1'b1;
        step(1);
        wr_ps2 = 1'b0;
      end
    join
    step(20);
    check("frame_bits", seen, model_frame(b));
    check("rts_hold", rts_cnt, HOLD);
    check("done_count", done_cnt, 1);
    check("err_count", err_cnt, ack_low ? 0 : 1);
    check("idle_after", tx_idle, 1);
    done_allowed = 1'b0;
    model_idle = 1'b1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    check("model_ED", model_frame(8'hED), 10'h3ED);
    check("model_F4", model_frame(8'hF4), 10'h2F4);
    check("model_00", model_frame(8'h00), 10'h300);

    step(5);
    check("rst_idle", tx_idle, 1);
    check("rst_done", tx_done_tick, 0);
    check("rst_err", tx_err, 0);
    check("rst_ps2c", ps2c, 1);
    check("rst_ps2d", ps2d, 1);
    reset = 1'b0;
    model_idle = 1'b1;
    step(50);

    run_frame(8'hED, 1'b1, 1'b0, 1'b0);
    run_frame(8'hF4, 1'b1, 1'b0, 1'b0);
    run_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    run_frame(8'hED, 1'b1, 1'b1, 1'b1);

    clear_counts();
    send(8'hED);
    dev_frame(4, 1'b0, 1'b0, seen);
    done_allowed = 1'b1;
    t = 0;
    while (done_cnt == 0 && t < 1000) begin
      step(1);
      t++;
    end
    check("timeout_done", done_cnt, 1);
    check("timeout_err", err_cnt, 1);
    check("timeout_window", (done_cyc - last_fall_cyc >= TMO) && (done_cyc - last_fall_cyc <= TMO + FL + 6), 1);
    check("timeout_bits", seen[3:0], 4'hD);
    check("timeout_ps2c", ps2c, 1);
    check("timeout_ps2d", ps2d, 1);
    check("timeout_idle", tx_idle, 1);
    step(5);
    done_allowed = 1'b0;
    model_idle = 1'b1;
    step(20);
    run_frame(8'hF4, 1'b1, 1'b0, 1'b0);

    clear_counts();
    send(8'h00);
    dev_frame(3, 1'b0, 1'b0, seen);
    check("pre_rst_data_low", ps2d, 0);
    check("pre_rst_busy", tx_idle, 0);
    #3 reset = 1'b1;
    #1;
    check("arst_ps2c", ps2c, 1);
    check("arst_ps2d", ps2d, 1);
    check("arst_idle", tx_idle, 1);
    check("arst_done", tx_done_tick, 0);
    step(3);
    reset = 1'b0;
    model_idle = 1'b1;
    step(50);
    check("arst_no_done", done_cnt, 0);
    check("arst_no_err", err_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
